// File: rtl/time_set_ctrl.sv
// time_set_ctrl: push-button time-setting front end for the 12-hour clock.
// Debounces btn_mode/btn_up/btn_down, runs the RUN -> SET_HR -> SET_MIN ->
// COMMIT edit FSM, and returns the edited BCD time with load/hold/blank.
// Optional feature macro: AUTO_REPEAT_EN (held up/down auto-repeats steps).
module time_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BLINK_CYCLES    = 25000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 20000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [3:0] cur_bcd0,
    input  logic [3:0] cur_bcd1,
    input  logic [3:0] cur_bcd2,
    input  logic [3:0] cur_bcd3,
    output logic [3:0] set_bcd0,
    output logic [3:0] set_bcd1,
    output logic [3:0] set_bcd2,
    output logic [3:0] set_bcd3,
    output logic       load,
    output logic       hold,
    output logic [3:0] blank,
    output logic [1:0] mode
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int BL_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    state_t state;

    // Button index: 0 = mode, 1 = up, 2 = down
    logic [2:0]      raw;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      deb;
    logic [2:0]      deb_q;
    logic [2:0]      press;
    logic [DB_W-1:0] db_cnt [3];

    // Edit registers: hr tens, hr ones, min tens, min ones
    logic [3:0] e_h1, e_h0, e_m1, e_m0;

    logic [BL_W-1:0] bl_cnt;
    logic            phase;

    logic rep_up;
    logic rep_dn;
    logic step_up;
    logic step_dn;
    logic editing;

    logic       hr_ok, min_ok;
    logic [3:0] cap_h1, cap_h0, cap_m1, cap_m0;
    logic [3:0] hu_h1, hu_h0, hd_h1, hd_h0;
    logic [3:0] mu_m1, mu_m0, md_m1, md_m0;

    assign raw   = {btn_down, btn_up, btn_mode};
    assign press = deb & ~deb_q;

    // Two-flop synchronizer plus stability counter per button
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_cnt[i] <= '0;
                    deb[i]    <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign editing = (state == SET_HR) || (state == SET_MIN);

`ifdef AUTO_REPEAT_EN
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RP_W   = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;

    logic [RP_W-1:0] rep_cnt;
    logic            rep_armed;
    logic            rep_held;
    logic            rep_fire;
    logic [RP_W-1:0] rep_limit;

    // Exactly one of up/down held while editing; a mode press ends the hold window
    assign rep_held  = editing && (deb[1] ^ deb[2]) && !press[0];
    assign rep_limit = rep_armed ? RP_W'(REPEAT_RATE - 1) : RP_W'(REPEAT_DELAY - 1);
    assign rep_fire  = rep_held && (rep_cnt == rep_limit);
    assign rep_up    = rep_fire & deb[1];
    assign rep_dn    = rep_fire & deb[2];

    // Auto-repeat timer: first step after REPEAT_DELAY, then every REPEAT_RATE
    always_ff @(posedge clk) begin
        if (rst || !rep_held) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else if (rep_fire) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b1;
        end else begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end
`else
    assign rep_up = 1'b0;
    assign rep_dn = 1'b0;

    // Repeat timing parameters only take effect with the feature built in
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_repeat_cfg_idle
    end
`endif

    // Step request decode: mode press wins, simultaneous up+down cancels
    always_comb begin
        step_up = 1'b0;
        step_dn = 1'b0;
        if (editing && !press[0]) begin
            if (press[1] && !press[2]) step_up = 1'b1;
            if (press[2] && !press[1]) step_dn = 1'b1;
            if (rep_up) step_up = 1'b1;
            if (rep_dn) step_dn = 1'b1;
        end
    end

    // Captured-time sanitising and next-digit arithmetic for both fields
    always_comb begin
        hr_ok  = ((cur_bcd3 == 4'd0) && (cur_bcd2 >= 4'd1) && (cur_bcd2 <= 4'd9)) ||
                 ((cur_bcd3 == 4'd1) && (cur_bcd2 <= 4'd2));
        min_ok = (cur_bcd1 <= 4'd5) && (cur_bcd0 <= 4'd9);
        cap_h1 = hr_ok  ? cur_bcd3 : 4'd1;
        cap_h0 = hr_ok  ? cur_bcd2 : 4'd2;
        cap_m1 = min_ok ? cur_bcd1 : 4'd0;
        cap_m0 = min_ok ? cur_bcd0 : 4'd0;

        hu_h1 = e_h1;
        hu_h0 = e_h0 + 4'd1;
        if (e_h1 == 4'd1 && e_h0 == 4'd2) begin
            hu_h1 = 4'd0;
            hu_h0 = 4'd1;
        end else if (e_h0 == 4'd9) begin
            hu_h1 = 4'd1;
            hu_h0 = 4'd0;
        end

        hd_h1 = e_h1;
        hd_h0 = e_h0 - 4'd1;
        if (e_h1 == 4'd0 && e_h0 == 4'd1) begin
            hd_h1 = 4'd1;
            hd_h0 = 4'd2;
        end else if (e_h0 == 4'd0) begin
            hd_h1 = 4'd0;
            hd_h0 = 4'd9;
        end

        mu_m1 = e_m1;
        mu_m0 = e_m0 + 4'd1;
        if (e_m0 == 4'd9) begin
            mu_m0 = 4'd0;
            mu_m1 = (e_m1 == 4'd5) ? 4'd0 : e_m1 + 4'd1;
        end

        md_m1 = e_m1;
        md_m0 = e_m0 - 4'd1;
        if (e_m0 == 4'd0) begin
            md_m0 = 4'd9;
            md_m1 = (e_m1 == 4'd0) ? 4'd5 : e_m1 - 4'd1;
        end
    end

    // Edit FSM with registered load/hold, edit registers and blink timer
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            load   <= 1'b0;
            hold   <= 1'b0;
            e_h1   <= 4'd1;
            e_h0   <= 4'd2;
            e_m1   <= 4'd0;
            e_m0   <= 4'd0;
            bl_cnt <= '0;
            phase  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    load   <= 1'b0;
                    bl_cnt <= '0;
                    phase  <= 1'b0;
                    if (press[0]) begin
                        state <= SET_HR;
                        hold  <= 1'b1;
                        e_h1  <= cap_h1;
                        e_h0  <= cap_h0;
                        e_m1  <= cap_m1;
                        e_m0  <= cap_m0;
                    end
                end
                SET_HR, SET_MIN: begin
                    if (press[0]) begin
                        state  <= (state == SET_HR) ? SET_MIN : COMMIT;
                        load   <= (state == SET_MIN);
                        bl_cnt <= '0;
                        phase  <= 1'b0;
                    end else if (step_up || step_dn) begin
                        bl_cnt <= '0;
                        phase  <= 1'b0;
                        if (state == SET_HR) begin
                            e_h1 <= step_up ? hu_h1 : hd_h1;
                            e_h0 <= step_up ? hu_h0 : hd_h0;
                        end else begin
                            e_m1 <= step_up ? mu_m1 : md_m1;
                            e_m0 <= step_up ? mu_m0 : md_m0;
                        end
                    end else if (bl_cnt == BL_W'(BLINK_CYCLES - 1)) begin
                        bl_cnt <= '0;
                        phase  <= ~phase;
                    end else begin
                        bl_cnt <= bl_cnt + 1'b1;
                    end
                end
                COMMIT: begin
                    state  <= RUN;
                    load   <= 1'b0;
                    hold   <= 1'b0;
                    bl_cnt <= '0;
                    phase  <= 1'b0;
                end
                default: begin
                    state <= RUN;
                    load  <= 1'b0;
                    hold  <= 1'b0;
                end
            endcase
        end
    end

    // Blank mask: darken the field being edited during the blink-off phase
    always_comb begin
        blank = 4'b0000;
        if (state == SET_HR)  blank = {phase, phase, 2'b00};
        if (state == SET_MIN) blank = {2'b00, phase, phase};
    end

    assign mode     = state;
    assign set_bcd0 = e_m0;
    assign set_bcd1 = e_m1;
    assign set_bcd2 = e_h0;
    assign set_bcd3 = e_h1;

endmodule
